// File: rtl/hpdcache_regbank_req_ctrl.sv
// Request/response front end for a 1RW byte-enable register bank.
// Requests issue to the bank in their handshake cycle; read data is buffered in a 2-entry FIFO.
module hpdcache_regbank_req_ctrl #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [ADDR_SIZE-1:0]   req_addr_i,
  input  logic [DATA_SIZE-1:0]   req_wdata_i,
  input  logic [DATA_SIZE/8-1:0] req_be_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_SIZE-1:0]   rsp_rdata_o,
  output logic                   bank_cs_o,
  output logic                   bank_we_o,
  output logic [ADDR_SIZE-1:0]   bank_addr_o,
  output logic [DATA_SIZE-1:0]   bank_wdata_o,
  output logic [DATA_SIZE/8-1:0] bank_be_o,
  input  logic [DATA_SIZE-1:0]   bank_rdata_i
);

  // Valid/ready: a transfer happens on a port in any cycle where valid && ready are both high
  // at the rising edge. Request ready may depend on req_we_i and on rsp_ready_i.

  logic [1:0]           cnt_q, cnt_d;
  logic                 wptr_q, wptr_d;
  logic                 rptr_q, rptr_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [DATA_SIZE-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_SIZE-1:0] fifo_d [RSP_DEPTH];

  logic       push;
  logic       pop;
  logic [2:0] occ;
  logic       rd_room;
  logic       rd_acc;

  always_comb begin
    pop         = (cnt_q != 2'd0) && rsp_ready_i;
    push        = rd_pend_q;
    // Buffered plus in-flight reads, less the one leaving this cycle.
    occ         = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    rd_room     = (occ < 3'(RSP_DEPTH));
    req_ready_o = !rst && (req_we_i || rd_room);
    bank_cs_o   = req_valid_i && req_ready_o;
    bank_we_o   = req_we_i && bank_cs_o;
    rd_acc      = bank_cs_o && !req_we_i;

    rd_pend_d   = rd_acc;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
    wptr_d      = wptr_q ^ push;
    rptr_d      = rptr_q ^ pop;

    fifo_d      = fifo_q;
    if (push) begin
      fifo_d[wptr_q] = bank_rdata_i;
    end
  end

  assign bank_addr_o  = req_addr_i;
  assign bank_wdata_o = req_wdata_i;
  assign bank_be_o    = req_be_i;
  assign rsp_valid_o  = (cnt_q != 2'd0);
  assign rsp_rdata_o  = fifo_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 2'd0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_hpdcache_regbank_req_ctrl.sv
// Bench for hpdcache_regbank_req_ctrl: a bank model drives bank_rdata_i, and a queue-based
// model of outstanding reads predicts ready, response timing and response data.
module tb_hpdcache_regbank_req_ctrl;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] bank_rdata = '0;

  logic          req_ready_o;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          bank_cs_o;
  logic          bank_we_o;
  logic [AW-1:0] bank_addr_o;
  logic [DW-1:0] bank_wdata_o;
  logic [BW-1:0] bank_be_o;

  hpdcache_regbank_req_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RSP_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .bank_cs_o(bank_cs_o), .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o),
    .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    logic [31:0] a;
    logic [31:0] b;
    a = 32'h9E3779B9 * 32'(i + 1);
    b = 32'h85EBCA6B ^ (32'(i) * 32'h01000193);
    return {a, b};
  endfunction

  // ---------------- register bank model (1RW, byte enables, 1-cycle read) ----------------
  logic [DW-1:0] bank_mem [NW];
  logic          bank_init = 1'b0;
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < NW; i++) bank_mem[i] <= init_word(i);
      bank_init <= 1'b1;
    end else begin
      if (bank_cs_o && bank_we_o)
        for (int b = 0; b < BW; b++)
          if (bank_be_o[b]) bank_mem[bank_addr_o][b*8 +: 8] <= bank_wdata_o[b*8 +: 8];
      if (bank_cs_o && !bank_we_o) bank_rdata <= bank_mem[bank_addr_o];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int            acc_q [$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            rsp_cnt = 0;
  int            we_cnt = 0;
  bit            ref_init = 1'b0;

  always @(negedge clk) begin
    bit exp_valid;
    bit exp_pop;
    bit exp_ready;
    bit exp_cs;
    if (!ref_init) begin
      for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    cyc++;
    // A read accepted in cycle c can be presented from cycle c+2 on, in acceptance order.
    exp_valid = (exp_q.size() > 0) && (acc_q[0] <= cyc - 2);
    exp_pop   = exp_valid && rsp_ready;
    exp_ready = !rst && (req_we || ((exp_q.size() - int'(exp_pop)) < 2));
    exp_cs    = req_valid && exp_ready;

    checks++;
    if (rsp_valid_o !== exp_valid) begin
      errors++;
      $display("FAIL sb_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid_o, exp_valid);
    end
    checks++;
    if (req_ready_o !== exp_ready) begin
      errors++;
      $display("FAIL sb_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_ready);
    end
    checks++;
    if (bank_cs_o !== exp_cs || bank_we_o !== (exp_cs && req_we)) begin
      errors++;
      $display("FAIL sb_bank_cs_we cyc=%0d got=%b%b exp=%b%b", cyc, bank_cs_o, bank_we_o,
               exp_cs, exp_cs && req_we);
    end
    checks++;
    if (bank_addr_o !== req_addr || bank_wdata_o !== req_wdata || bank_be_o !== req_be) begin
      errors++;
      $display("FAIL sb_bank_pass cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, bank_addr_o,
               bank_wdata_o, bank_be_o, req_addr, req_wdata, req_be);
    end
    if (exp_pop) begin
      checks++;
      if (rsp_rdata_o !== exp_q[0]) begin
        errors++;
        $display("FAIL sb_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_rdata_o, exp_q[0]);
      end
      got_q.push_back(rsp_rdata_o);
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
      rsp_cnt++;
    end
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else if (exp_cs) begin
      if (req_we) begin
        for (int b = 0; b < BW; b++)
          if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        we_cnt++;
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
        acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [BW-1:0] be, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (req_ready_o) begin done = 1'b1; acc = cyc; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout got=not_accepted exp=accepted addr=%0d we=%b", addr, we);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = (exp_q.size() == 0);
    for (int i = 0; i < 30 && !idle; i++) begin
      @(posedge clk); #1;
      idle = (exp_q.size() == 0);
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL drain_timeout got=%0d_outstanding exp=0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
    @(negedge clk); #1;
    checks++;
    if (bank_cs_o !== 1'b0 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got=cs%b_rdy%b exp=cs0_rdy0", bank_cs_o, req_ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || bank_cs_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got=rdy%b_vld%b_cs%b exp=rdy1_vld0_cs0", req_ready_o,
               rsp_valid_o, bank_cs_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int a, w0, r0;
    w0 = we_cnt; r0 = rsp_cnt;
    rsp_ready = 1'b1;
    send(1'b1, 4'd3, 64'h1122334455667788, 8'hFF, a);
    send(1'b0, 4'd3, '0, '0, a);
    @(negedge clk); #1;
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_early got=%b exp=0", rsp_valid_o);
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL wr_rd_rsp got=%b/%h exp=1/1122334455667788", rsp_valid_o, rsp_rdata_o);
    end
    @(posedge clk); #1;
    wait_idle();
    checks++;
    if (we_cnt - w0 != 1 || rsp_cnt - r0 != 1) begin
      errors++;
      $display("FAIL wr_rd_counts got=we%0d_rsp%0d exp=we1_rsp1", we_cnt - w0, rsp_cnt - r0);
    end
  endtask

  task automatic test_partial_write();
    int a;
    rsp_ready = 1'b1;
    send(1'b1, 4'd3, 64'h00000000000000AA, 8'h01, a);
    send(1'b0, 4'd3, '0, '0, a);
    wait_idle();
    checks++;
    if (got_q[$] !== 64'h11223344556677AA) begin
      errors++;
      $display("FAIL partial_wr got=%h exp=11223344556677aa", got_q[$]);
    end
  endtask

  task automatic test_stall_drain();
    int a0, a1, a2, r0, g0;
    logic [DW-1:0] snap [3];
    for (int i = 0; i < 3; i++) snap[i] = ref_mem[i];
    r0 = rsp_cnt; g0 = got_q.size();
    rsp_ready = 1'b0;
    send(1'b0, 4'd0, '0, '0, a0);
    send(1'b0, 4'd1, '0, '0, a1);
    checks++;
    if (a1 != a0 + 1) begin
      errors++;
      $display("FAIL stall_b2b got=%0d exp=%0d", a1, a0 + 1);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_rd_ready got=%b exp=0", req_ready_o);
      end
      @(posedge clk); #1;
    end
    req_we = 1'b1; req_addr = 4'd5; req_wdata = {$urandom, $urandom}; req_be = 8'hFF;
    @(negedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1 || bank_we_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_wr_accept got=rdy%b_we%b exp=rdy1_we1", req_ready_o, bank_we_o);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(1'b0, 4'd2, '0, '0, a2);
    wait_idle();
    checks++;
    if (rsp_cnt - r0 != 3 || got_q.size() < g0 + 3) begin
      errors++;
      $display("FAIL drain_count got=%0d exp=3", rsp_cnt - r0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[g0 + i] !== snap[i]) begin
          errors++;
          $display("FAIL drain_order idx=%0d got=%h exp=%h", i, got_q[g0 + i], snap[i]);
        end
      end
    end
  endtask

  task automatic test_streaming();
    int r0;
    r0 = rsp_cnt;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req_addr = AW'($urandom_range(0, NW - 1));
      @(negedge clk); #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready i=%0d got=%b exp=1", i, req_ready_o);
      end
      if (i >= 2) begin
        checks++;
        if (rsp_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL stream_rsp i=%0d got=%b exp=1", i, rsp_valid_o);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle();
    checks++;
    if (rsp_cnt - r0 != 12) begin
      errors++;
      $display("FAIL stream_count got=%0d exp=12", rsp_cnt - r0);
    end
  endtask

  task automatic test_reset_midflight();
    int a, r0;
    rsp_ready = 1'b0;
    send(1'b0, 4'd4, '0, '0, a);
    send(1'b0, 4'd5, '0, '0, a);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd6;
    @(negedge clk); #1;
    checks++;
    if (bank_cs_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_during got=cs%b_vld%b exp=cs0_vld1", bank_cs_o, rsp_valid_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after got=%b exp=0", rsp_valid_o);
    end
    @(posedge clk); #1;
    r0 = rsp_cnt;
    rsp_ready = 1'b1;
    send(1'b0, 4'd7, '0, '0, a);
    wait_idle();
    checks++;
    if (rsp_cnt - r0 != 1 || got_q[$] !== ref_mem[7]) begin
      errors++;
      $display("FAIL midrst_next got=%0d/%h exp=1/%h", rsp_cnt - r0, got_q[$], ref_mem[7]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = ($urandom_range(0, 2) == 0);
      req_addr  = AW'($urandom_range(0, NW - 1));
      req_wdata = {$urandom, $urandom};
      req_be    = BW'($urandom_range(0, 255));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL random_end got=%b exp=0", rsp_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_stall_drain();
    test_streaming();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
